// File: rtl/spi_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : spi_transfer_scheduler
// Description : Round-robin arbiter that shares one multi-channel SPI master
//               between N_REQ requesters. A granted request is copied onto
//               spi_data and launched with a one-cycle spi_start pulse. The
//               scheduler then waits for spi_done or a timeout, returns the
//               received words tagged with the requester index, and enforces
//               GAP idle cycles before the next grant.
// Ports       : SCLK          block clock
//               reset         synchronous, active-low
//               req_valid     per-requester request valid
//               req_ready     per-requester accept (one-hot or zero)
//               req_data      packed request words, requester-major
//               spi_data      registered words presented to the SPI master
//               spi_start     one-cycle launch pulse
//               spi_done      SPI completion pulse
//               spi_rx        received words, valid with spi_done
//               resp_valid    response valid
//               resp_ready    response accept
//               resp_data     received words, or 0 on timeout
//               resp_id       index of the requester served
//               resp_timeout  transfer ended by timeout
// Revision    : 1.0 - initial release
// ============================================================================
module spi_transfer_scheduler #(
  parameter int N_REQ      = 4,
  parameter int N_CHANNELS = 3,
  parameter int SPI_WIDTH  = 12,
  parameter int TIMEOUT    = 1024,
  parameter int GAP        = 2
) (
  input  logic                                      SCLK,
  input  logic                                      reset,
  input  logic [N_REQ-1:0]                          req_valid,
  output logic [N_REQ-1:0]                          req_ready,
  input  logic [N_REQ*N_CHANNELS*SPI_WIDTH-1:0]     req_data,
  output logic [N_CHANNELS*SPI_WIDTH-1:0]           spi_data,
  output logic                                      spi_start,
  input  logic                                      spi_done,
  input  logic [N_CHANNELS*SPI_WIDTH-1:0]           spi_rx,
  output logic                                      resp_valid,
  input  logic                                      resp_ready,
  output logic [N_CHANNELS*SPI_WIDTH-1:0]           resp_data,
  output logic [$clog2(N_REQ)-1:0]                  resp_id,
  output logic                                      resp_timeout
);

  localparam int DW    = N_CHANNELS * SPI_WIDTH;
  localparam int ID_W  = $clog2(N_REQ);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LAUNCH  = 3'd1;
  localparam logic [2:0] S_WAIT    = 3'd2;
  localparam logic [2:0] S_RESPOND = 3'd3;
  localparam logic [2:0] S_GAP     = 3'd4;

  logic [2:0]       state;
  logic [2:0]       next_state;
  logic [ID_W-1:0]  last;
  logic [ID_W-1:0]  grant;
  logic             grant_found;
  logic [CNT_W-1:0] tcnt;
  logic [GAP_W-1:0] gcnt;
  logic             tcnt_expired;
  logic             gap_done;

  function automatic logic [ID_W-1:0] wrap_idx(input int v);
    return ID_W'(v % N_REQ);
  endfunction

  // Scan from the highest offset down so the lowest offset after 'last'
  // is the one left standing: that is the round-robin winner.
  always_comb begin
    grant       = '0;
    grant_found = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req_valid[wrap_idx(int'(last) + i)]) begin
        grant       = wrap_idx(int'(last) + i);
        grant_found = 1'b1;
      end
    end
  end

  assign tcnt_expired = (tcnt == CNT_W'(TIMEOUT - 1));
  assign gap_done     = (gcnt == GAP_W'(GAP - 1));

  // State register
  always_ff @(posedge SCLK) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:    if (grant_found) next_state = S_LAUNCH;
      S_LAUNCH:  next_state = S_WAIT;
      S_WAIT:    if (spi_done || tcnt_expired) next_state = S_RESPOND;
      S_RESPOND: if (resp_ready) next_state = (GAP == 0) ? S_IDLE : S_GAP;
      S_GAP:     if (gap_done) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  // Outputs. req_ready is held off while reset is asserted so nothing is
  // accepted on a cycle the scheduler is being cleared.
  always_comb begin
    req_ready  = '0;
    spi_start  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      S_IDLE:    if (reset && grant_found) req_ready[grant] = 1'b1;
      S_LAUNCH:  spi_start  = 1'b1;
      S_RESPOND: resp_valid = 1'b1;
      default:   ;
    endcase
  end

  // Datapath registers and counters
  always_ff @(posedge SCLK) begin
    if (!reset) begin
      last         <= ID_W'(N_REQ - 1);
      spi_data     <= '0;
      resp_data    <= '0;
      resp_id      <= '0;
      resp_timeout <= 1'b0;
      tcnt         <= '0;
      gcnt         <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            spi_data <= req_data[int'(grant)*DW +: DW];
            resp_id  <= grant;
            last     <= grant;
          end
        end
        S_LAUNCH: tcnt <= '0;
        S_WAIT: begin
          tcnt <= tcnt + CNT_W'(1);
          // A completion in the final timeout cycle still counts as success.
          if (spi_done) begin
            resp_data    <= spi_rx;
            resp_timeout <= 1'b0;
          end else if (tcnt_expired) begin
            resp_data    <= '0;
            resp_timeout <= 1'b1;
          end
        end
        S_RESPOND: gcnt <= '0;
        S_GAP:     gcnt <= gcnt + GAP_W'(1);
        default:   ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_transfer_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_transfer_scheduler
// Description : Self-checking bench for spi_transfer_scheduler. Directed
//               transfer table, reset-in-WAIT sequence, then randomized
//               transfers checked against a round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_transfer_scheduler;

  localparam int NR = 4;
  localparam int NC = 3;
  localparam int W  = 12;
  localparam int TO = 1024;
  localparam int GP = 2;
  localparam int DW = NC * W;

  typedef struct {
    logic [3:0]    vmask;
    logic [DW-1:0] word;
    int            delay;   // WAIT-cycle index of spi_done, -1 = never
    logic [DW-1:0] rx;
    int            hold;    // cycles resp_ready is held low
    bit            stray;   // pulse spi_done while responding
    int            exp_id;
    bit            exp_to;
  } vec_t;

  logic                 SCLK;
  logic                 reset;
  logic [NR-1:0]        req_valid;
  logic [NR-1:0]        req_ready;
  logic [NR*DW-1:0]     req_data;
  logic [DW-1:0]        spi_data;
  logic                 spi_start;
  logic                 spi_done;
  logic [DW-1:0]        spi_rx;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DW-1:0]        resp_data;
  logic [1:0]           resp_id;
  logic                 resp_timeout;

  int passed = 0;
  int total  = 0;
  int model_last;
  vec_t tbl[15];

  spi_transfer_scheduler #(
    .N_REQ(NR), .N_CHANNELS(NC), .SPI_WIDTH(W), .TIMEOUT(TO), .GAP(GP)
  ) dut (
    .SCLK(SCLK), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .spi_data(spi_data), .spi_start(spi_start), .spi_done(spi_done),
    .spi_rx(spi_rx), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_id(resp_id), .resp_timeout(resp_timeout)
  );

  initial SCLK = 1'b0;
  always #5 SCLK = ~SCLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  // One complete transfer: accept, launch, SPI completion/timeout,
  // optional back-pressure, response handshake and gap.
  task automatic run_xfer(input vec_t v);
    logic [DW-1:0] exp_data;
    int exp_lat;
    int n;
    bit got;
    exp_lat  = v.exp_to ? TO + 1 : v.delay + 2;
    exp_data = v.exp_to ? '0 : v.rx;

    @(negedge SCLK);
    req_valid = v.vmask;
    for (int r = 0; r < NR; r++) req_data[r*DW +: DW] = rand36();
    req_data[v.exp_id*DW +: DW] = v.word;
    #1;
    check("req_ready_onehot", 64'(req_ready), 64'(1) << v.exp_id);
    @(posedge SCLK);
    @(negedge SCLK);
    req_valid = '0;
    #1;
    check("spi_start_launch", 64'(spi_start), 64'(1));
    check("spi_data", 64'(spi_data), 64'(v.word));
    model_last = v.exp_id;

    got = 1'b0;
    n   = 0;
    while (!got && n < TO + 8) begin
      @(negedge SCLK);
      n++;
      spi_done = (n - 1 == v.delay);
      spi_rx   = (n - 1 == v.delay) ? v.rx : rand36();
      #1;
      if (spi_start) check("spi_start_single", 64'(spi_start), 64'(0));
      got = resp_valid;
    end
    spi_done = 1'b0;
    check("resp_latency", 64'(n), 64'(exp_lat));
    check("resp_id", 64'(resp_id), 64'(v.exp_id));
    check("resp_data", 64'(resp_data), 64'(exp_data));
    check("resp_timeout", 64'(resp_timeout), 64'(v.exp_to));

    for (int h = 0; h < v.hold; h++) begin
      @(negedge SCLK);
      req_valid = 4'hF;
      spi_done  = v.stray && (h == 0);
      spi_rx    = ~v.rx;
      #1;
      check("hold_stable",
            64'({resp_valid, req_ready, spi_start, resp_timeout, resp_id, resp_data}),
            64'({1'b1, 4'b0000, 1'b0, v.exp_to, 2'(v.exp_id), exp_data}));
    end

    @(negedge SCLK);
    req_valid  = '0;
    spi_done   = 1'b0;
    resp_ready = 1'b1;
    #1;
    check("resp_at_handshake", 64'({resp_valid, resp_data}), 64'({1'b1, exp_data}));
    @(posedge SCLK);
    @(negedge SCLK);
    resp_ready = 1'b0;
    for (int g = 0; g < GP; g++) begin
      req_valid = 4'hF;
      #1;
      check("gap_quiet", 64'({resp_valid, req_ready, spi_start}), 64'(0));
      @(negedge SCLK);
    end
    req_valid = 4'hF;
    #1;
    check("gap_end_ready", 64'(req_ready), 64'(1) << ((model_last + 1) % NR));
    req_valid = '0;
  endtask

  initial begin
    vec_t rv;
    int   g;

    reset      = 1'b0;
    req_valid  = '0;
    req_data   = '0;
    spi_done   = 1'b0;
    spi_rx     = '0;
    resp_ready = 1'b0;

    for (int i = 0; i < 8; i++) begin
      tbl[i] = '{4'hF, DW'(36'h0A1B2C3D4 * (i + 1)), i * 3, DW'(36'h13579BDF1 * (i + 2)),
                 0, 1'b0, i % 4, 1'b0};
    end
    tbl[8]  = '{4'b0100, 36'h789456123, 49, 36'h012DEFABC, 0, 1'b0, 2, 1'b0};
    tbl[9]  = '{4'b0010, 36'h0F0F0F0F0, -1, 36'h111222333, 0, 1'b0, 1, 1'b1};
    tbl[10] = '{4'b1001, 36'h555AAA555, 7,  36'h9876543A1, 0, 1'b0, 3, 1'b0};
    tbl[11] = '{4'b0001, 36'h321654987, 5,  36'hFEDCBA987, 20, 1'b0, 0, 1'b0};
    tbl[12] = '{4'b0110, 36'hCAFEBEEF1, TO - 1, 36'h2468ACE02, 3, 1'b1, 1, 1'b0};
    tbl[13] = '{4'b1001, 36'h1A2B3C4D5, 10, 36'h6E7F80912, 0, 1'b0, 0, 1'b0};
    tbl[14] = '{4'b1000, 36'hABCDEF012, 2,  36'h345678901, 1, 1'b1, 3, 1'b0};

    repeat (3) @(posedge SCLK);
    #1;
    check("reset_ctrl", 64'({req_ready, spi_start, resp_valid, resp_timeout, resp_id}), 64'(0));
    check("reset_spi_data", 64'(spi_data), 64'(0));
    check("reset_resp_data", 64'(resp_data), 64'(0));
    @(negedge SCLK);
    reset = 1'b1;
    model_last = NR - 1;

    for (int i = 0; i <= 12; i++) run_xfer(tbl[i]);

    // Reset while waiting on the SPI master
    @(negedge SCLK);
    req_valid = 4'hF;
    #1;
    check("pre_reset_grant", 64'(req_ready), 64'(1) << ((model_last + 1) % NR));
    @(posedge SCLK);
    @(negedge SCLK);
    req_valid = '0;
    repeat (2) @(negedge SCLK);
    reset = 1'b0;
    @(posedge SCLK);
    #1;
    check("wait_reset_ctrl", 64'({req_ready, spi_start, resp_valid, resp_timeout, resp_id}), 64'(0));
    check("wait_reset_spi_data", 64'(spi_data), 64'(0));
    check("wait_reset_resp_data", 64'(resp_data), 64'(0));
    @(negedge SCLK);
    reset = 1'b1;
    model_last = NR - 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge SCLK);
      #1;
      check("post_reset_idle", 64'({spi_start, resp_valid}), 64'(0));
    end
    run_xfer(tbl[13]);
    run_xfer(tbl[14]);

    // Randomized transfers against the round-robin reference model
    for (int t = 0; t < 24; t++) begin
      rv.vmask = 4'($urandom_range(1, 15));
      g = -1;
      for (int k = 1; k <= NR; k++)
        if (g < 0 && rv.vmask[(model_last + k) % NR]) g = (model_last + k) % NR;
      rv.word   = rand36();
      rv.delay  = $urandom_range(0, 40);
      rv.rx     = rand36();
      rv.hold   = $urandom_range(0, 3);
      rv.stray  = 1'($urandom_range(0, 1));
      rv.exp_id = g;
      rv.exp_to = 1'b0;
      run_xfer(rv);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
